gate_fuser: RTL and testbench

streaming recomposer; merges NOT followed by AND/OR back into single ANDNOT/ORNOT records (Y = A & ~B / A | ~B).
REQ-013 FSM states: IDLE (holder empty), HELD (holder contains one single-use NOT).
REQ-014 out_free = !m_valid | m_ready; m_* is a one-entry register, updated only when out_free.
REQ-015 IDLE: s_ready = out_free; accepted NOT with s_single=1 -> stored in holder, goes to HELD, no output.
REQ-016 IDLE: any other accepted record -> copied unchanged to m_*, m_valid=1 next cycle (latency 1).
REQ-017 HELD match-B: s_op in {AND,OR}, s_b == h_y, s_a != h_y -> emit op+2 (ANDNOT/ORNOT), m_a=s_a, m_b=h_a, m_y=s_y, go IDLE.
REQ-018 HELD match-A: s_op in {AND,OR}, s_a == h_y, s_b != h_y -> emit op+2, m_a=s_b, m_b=h_a, m_y=s_y, go IDLE.
REQ-019 s_a == s_b == h_y is a no-match.
REQ-020 HELD: s_ready = out_free & match & !flush (ready may depend on s_valid/s_* combinationally).
REQ-021 HELD no-match with s_valid, out_free -> emit held NOT unchanged, go IDLE; incoming stays stalled and is processed from IDLE next cycle.
REQ-022 HELD with flush and out_free -> emit held NOT, go IDLE; flush beats simultaneous match; flush in IDLE has no effect.
REQ-023 HELD with s_valid low and no flush -> hold indefinitely, no output.
REQ-024 fused_cnt increments once per emitted fusion and saturates at 16'hFFFF.
REQ-025 m_* remain stable while m_valid & !m_ready.
REQ-026 Records are never reordered, duplicated or dropped except the NOT consumed by a fusion.

Reset
REQ-027 rst high at a clock edge -> state IDLE, m_valid=0, fused_cnt=0, holder discarded; m_op/m_a/m_b/m_y reset to 0.
REQ-028 s_ready is 0 while rst is high; reset mid-operation loses the held record without emitting it.

Structure
REQ-029 Opcode constants are defined in the shared gate-ops include, which the decomposition techmaps also use.
REQ-030 There is no sub-module; the match comparator and output register are inline.

Verification
REQ-031 NOT(a=3,y=9,single=1), AND(a=5,b=9,y=12) -> one record ANDNOT a=5 b=3 y=12; fused_cnt=1.
REQ-032 NOT(3->9,single), OR(a=9,b=5,y=12) -> ORNOT a=5 b=3 y=12 (swap path).
REQ-033 NOT(3->9,single), XOR(5,6->12) -> NOT(3->9) then XOR(5,6->12), with one stall cycle on s_ready.
REQ-034 NOT(3->9,single), idle 5 cycles, flush -> NOT(3->9) emitted once; flush with simultaneous matching AND -> NOT first, then the AND unfused.
REQ-035 m_ready held low 4 cycles during a 10-record stream -> no loss, no reorder, m_* stable while stalled.
REQ-036 rst asserted in HELD -> no output, fused_cnt=0, next NOT(single) is held normally.

---
 rtl/gate_fuser_pkg.sv | 43 ++++
 rtl/gate_fuser.sv | 172 +++++++++++++++++
 tb/tb_gate_fuser.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_fuser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gate_fuser_pkg                                                |
// | Purpose  : Shared gate-operation encodings, FSM state type and helper    |
// |            functions for the gate fuser and the decomposition techmaps.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package gate_fuser_pkg;

  // Gate opcodes carried on the record streams.
  typedef enum logic [2:0] {
    OP_NOT    = 3'd0,
    OP_AND    = 3'd1,
    OP_OR     = 3'd2,
    OP_ANDNOT = 3'd3,
    OP_ORNOT  = 3'd4,
    OP_XOR    = 3'd5,
    OP_BUF    = 3'd6,
    OP_RSVD   = 3'd7
  } gate_op_e;

  // Fuser holder state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } fuser_state_e;

  localparam int          CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // AND/OR map onto ANDNOT/ORNOT by adding two to the opcode.
  function automatic logic [2:0] fuse_op(input logic [2:0] op);
    return op + 3'd2;
  endfunction

  // True for the two opcodes that can absorb a preceding inverter.
  function automatic logic is_and_or(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_fuser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gate_fuser                                                    |
// | Purpose  : Streaming recomposer. A single-use NOT followed by an AND/OR  |
// |            that consumes its output is merged into one ANDNOT/ORNOT      |
// |            record; all other records pass through in order.              |
// | Ports    : clk, rst        clock, synchronous active-high reset          |
// |            s_valid/s_ready input record handshake                        |
// |            s_op,s_a,s_b,s_y,s_single  input record                       |
// |            flush           releases a held NOT                           |
// |            m_valid/m_ready output record handshake                       |
// |            m_op,m_a,m_b,m_y output record (registered)                   |
// |            fused_cnt       saturating count of fusions emitted           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module gate_fuser
  import gate_fuser_pkg::*;
#(
  parameter int NET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [2:0]       s_op,
  input  logic [NET_W-1:0] s_a,
  input  logic [NET_W-1:0] s_b,
  input  logic [NET_W-1:0] s_y,
  input  logic             s_single,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       m_op,
  output logic [NET_W-1:0] m_a,
  output logic [NET_W-1:0] m_b,
  output logic [NET_W-1:0] m_y,
  output logic [CNT_W-1:0] fused_cnt
);

  fuser_state_e     state_q, state_d;

  // Holder for one single-use NOT awaiting its consumer.
  logic [NET_W-1:0] h_a_q, h_a_d;
  logic [NET_W-1:0] h_b_q, h_b_d;
  logic [NET_W-1:0] h_y_q, h_y_d;

  // One-entry output register.
  logic             m_valid_q, m_valid_d;
  logic [2:0]       m_op_q, m_op_d;
  logic [NET_W-1:0] m_a_q, m_a_d;
  logic [NET_W-1:0] m_b_q, m_b_d;
  logic [NET_W-1:0] m_y_q, m_y_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_out_free;
  logic             w_a_hit;
  logic             w_b_hit;
  logic             w_match;

  assign w_out_free = !m_valid_q || m_ready;

  // Exactly one operand must be the held net; if both are, the NOT output
  // is used twice by this gate and cannot be folded into a single input.
  assign w_a_hit = (s_a == h_y_q);
  assign w_b_hit = (s_b == h_y_q);
  assign w_match = is_and_or(s_op) && (w_a_hit ^ w_b_hit);

  always_comb begin
    state_d   = state_q;
    h_a_d     = h_a_q;
    h_b_d     = h_b_q;
    h_y_d     = h_y_q;
    m_valid_d = m_valid_q;
    m_op_d    = m_op_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    m_y_d     = m_y_q;
    cnt_d     = cnt_q;
    s_ready   = 1'b0;

    // A consumed output slot empties unless something new is loaded below.
    if (w_out_free) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        s_ready = w_out_free;
        if (s_valid && w_out_free) begin
          if ((s_op == OP_NOT) && s_single) begin
            h_a_d   = s_a;
            h_b_d   = s_b;
            h_y_d   = s_y;
            state_d = ST_HELD;
          end else begin
            m_valid_d = 1'b1;
            m_op_d    = s_op;
            m_a_d     = s_a;
            m_b_d     = s_b;
            m_y_d     = s_y;
          end
        end
      end

      ST_HELD: begin
        // Only a fusable record is taken here; anything else waits until
        // the held NOT has been released and is then handled from IDLE.
        s_ready = w_out_free && w_match && !flush;
        if (w_out_free) begin
          if (flush || (s_valid && !w_match)) begin
            m_valid_d = 1'b1;
            m_op_d    = OP_NOT;
            m_a_d     = h_a_q;
            m_b_d     = h_b_q;
            m_y_d     = h_y_q;
            state_d   = ST_IDLE;
          end else if (s_valid) begin
            m_valid_d = 1'b1;
            m_op_d    = fuse_op(s_op);
            m_a_d     = w_b_hit ? s_a : s_b;
            m_b_d     = h_a_q;
            m_y_d     = s_y;
            state_d   = ST_IDLE;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    endcase

    if (rst) begin
      s_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_a_q     <= '0;
      h_b_q     <= '0;
      h_y_q     <= '0;
      m_valid_q <= 1'b0;
      m_op_q    <= '0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_y_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_a_q     <= h_a_d;
      h_b_q     <= h_b_d;
      h_y_q     <= h_y_d;
      m_valid_q <= m_valid_d;
      m_op_q    <= m_op_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      m_y_q     <= m_y_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_op      = m_op_q;
  assign m_a       = m_a_q;
  assign m_b       = m_b_q;
  assign m_y       = m_y_q;
  assign fused_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_fuser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gate_fuser                                                 |
// | Purpose  : Directed self-checking bench for gate_fuser.                  |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_gate_fuser;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_op;
  logic [7:0]  s_a, s_b, s_y;
  logic        s_single;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_op;
  logic [7:0]  m_a, m_b, m_y;
  logic [15:0] fused_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [26:0] q[$];
  logic        stall_prev = 1'b0;
  logic [26:0] prev_rec   = '0;

  always #5 clk = ~clk;

  gate_fuser #(.NET_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_op     (s_op),
    .s_a      (s_a),
    .s_b      (s_b),
    .s_y      (s_y),
    .s_single (s_single),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_op     (m_op),
    .m_a      (m_a),
    .m_b      (m_b),
    .m_y      (m_y),
    .fused_cnt(fused_cnt)
  );

  function automatic logic [26:0] rec(input int op, input int a, input int b, input int y);
    return {op[2:0], a[7:0], b[7:0], y[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int idx, input logic [26:0] exp);
    logic [26:0] obs;
    obs = (idx < q.size()) ? q[idx] : 'x;
    chk(tag, {5'b0, obs}, {5'b0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one record and returns once it has been accepted; reports the
  // number of cycles s_ready was low while s_valid was offered.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] y, input logic sg, output int stalls);
    stalls   = 0;
    s_op     = op;
    s_a      = a;
    s_b      = b;
    s_y      = y;
    s_single = sg;
    s_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      if (stalls > 50) begin
        n_vec++;
        n_err++;
        $error("FAIL send_timeout observed=stalled expected=accept");
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Output monitor: records each handshake and checks the output holds
  // steady across back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, m_valid}, 32'd1);
        chk("stall_stable", {5'b0, m_op, m_a, m_b, m_y}, {5'b0, prev_rec});
      end
      if (m_valid && m_ready) q.push_back({m_op, m_a, m_b, m_y});
      stall_prev <= m_valid && !m_ready;
      prev_rec   <= {m_op, m_a, m_b, m_y};
    end
  end

  logic [2:0] str_op [10];
  logic [7:0] str_a  [10];
  logic [7:0] str_b  [10];
  logic [7:0] str_y  [10];
  logic       str_sg [10];
  logic [26:0] str_exp [9];

  initial begin
    int st;
    rst = 1'b1; s_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_y = '0;
    s_single = 1'b0; flush = 1'b0; m_ready = 1'b1;

    // Reset state
    tick(2);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_cnt", {16'b0, fused_cnt}, 32'd0);
    chk("rst_m_rec", {5'b0, m_op, m_a, m_b, m_y}, 32'd0);
    rst = 1'b0;
    tick(1);

    // NOT then AND consuming it on B -> ANDNOT
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    send(3'd1, 8'd5, 8'd9, 8'd12, 1'b0, st);
    tick(3);
    chk("andnot_count", q.size(), 32'd1);
    chk_rec("andnot_rec", 0, rec(3, 5, 3, 12));
    chk("andnot_cnt", {16'b0, fused_cnt}, 32'd1);
    q.delete();

    // NOT then OR consuming it on A -> ORNOT with operands swapped
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    send(3'd2, 8'd9, 8'd5, 8'd12, 1'b0, st);
    tick(3);
    chk("ornot_count", q.size(), 32'd1);
    chk_rec("ornot_rec", 0, rec(4, 5, 3, 12));
    chk("ornot_cnt", {16'b0, fused_cnt}, 32'd2);
    q.delete();

    // NOT then unrelated XOR -> both pass, one stall cycle
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    send(3'd5, 8'd5, 8'd6, 8'd12, 1'b0, st);
    chk("nomatch_stall", st, 32'd1);
    tick(3);
    chk("nomatch_count", q.size(), 32'd2);
    chk_rec("nomatch_rec0", 0, rec(0, 3, 0, 9));
    chk_rec("nomatch_rec1", 1, rec(5, 5, 6, 12));
    q.delete();

    // Both operands on the held net -> not fusable
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    send(3'd1, 8'd9, 8'd9, 8'd12, 1'b0, st);
    tick(3);
    chk("dual_count", q.size(), 32'd2);
    chk_rec("dual_rec0", 0, rec(0, 3, 0, 9));
    chk_rec("dual_rec1", 1, rec(1, 9, 9, 12));
    chk("dual_cnt", {16'b0, fused_cnt}, 32'd2);
    q.delete();

    // Held NOT waits indefinitely, then flush releases it once
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    tick(5);
    chk("hold_count", q.size(), 32'd0);
    chk("hold_m_valid", {31'b0, m_valid}, 32'd0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    chk("flush_count", q.size(), 32'd1);
    chk_rec("flush_rec", 0, rec(0, 3, 0, 9));
    q.delete();

    // Flush wins over a simultaneous matching AND
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    flush = 1'b1;
    s_op = 3'd1; s_a = 8'd5; s_b = 8'd9; s_y = 8'd12; s_single = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", {31'b0, s_ready}, 32'd0);
    tick(1);
    flush = 1'b0;
    send(3'd1, 8'd5, 8'd9, 8'd12, 1'b0, st);
    tick(3);
    chk("flushmatch_count", q.size(), 32'd2);
    chk_rec("flushmatch_rec0", 0, rec(0, 3, 0, 9));
    chk_rec("flushmatch_rec1", 1, rec(1, 5, 9, 12));
    chk("flushmatch_cnt", {16'b0, fused_cnt}, 32'd2);
    q.delete();

    // Ten-record stream with four cycles of output back-pressure
    str_op[0] = 3'd6; str_a[0] = 8'd1;  str_b[0] = 8'd0; str_y[0] = 8'd2;  str_sg[0] = 1'b0;
    str_op[1] = 3'd5; str_a[1] = 8'd2;  str_b[1] = 8'd3; str_y[1] = 8'd4;  str_sg[1] = 1'b0;
    str_op[2] = 3'd0; str_a[2] = 8'd4;  str_b[2] = 8'd0; str_y[2] = 8'd5;  str_sg[2] = 1'b0;
    str_op[3] = 3'd1; str_a[3] = 8'd5;  str_b[3] = 8'd2; str_y[3] = 8'd6;  str_sg[3] = 1'b0;
    str_op[4] = 3'd2; str_a[4] = 8'd6;  str_b[4] = 8'd1; str_y[4] = 8'd7;  str_sg[4] = 1'b0;
    str_op[5] = 3'd0; str_a[5] = 8'd1;  str_b[5] = 8'd0; str_y[5] = 8'd20; str_sg[5] = 1'b1;
    str_op[6] = 3'd1; str_a[6] = 8'd20; str_b[6] = 8'd7; str_y[6] = 8'd21; str_sg[6] = 1'b0;
    str_op[7] = 3'd5; str_a[7] = 8'd21; str_b[7] = 8'd6; str_y[7] = 8'd22; str_sg[7] = 1'b0;
    str_op[8] = 3'd6; str_a[8] = 8'd22; str_b[8] = 8'd0; str_y[8] = 8'd23; str_sg[8] = 1'b0;
    str_op[9] = 3'd2; str_a[9] = 8'd23; str_b[9] = 8'd4; str_y[9] = 8'd24; str_sg[9] = 1'b0;
    str_exp[0] = rec(6, 1, 0, 2);
    str_exp[1] = rec(5, 2, 3, 4);
    str_exp[2] = rec(0, 4, 0, 5);
    str_exp[3] = rec(1, 5, 2, 6);
    str_exp[4] = rec(2, 6, 1, 7);
    str_exp[5] = rec(3, 7, 1, 21);
    str_exp[6] = rec(5, 21, 6, 22);
    str_exp[7] = rec(6, 22, 0, 23);
    str_exp[8] = rec(2, 23, 4, 24);
    fork
      begin
        int sst;
        for (int i = 0; i < 10; i++) begin
          send(str_op[i], str_a[i], str_b[i], str_y[i], str_sg[i], sst);
        end
      end
      begin
        tick(3);
        m_ready = 1'b0;
        tick(4);
        m_ready = 1'b1;
      end
    join
    tick(4);
    chk("stream_count", q.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk_rec($sformatf("stream_rec%0d", i), i, str_exp[i]);
    end
    chk("stream_cnt", {16'b0, fused_cnt}, 32'd3);
    q.delete();

    // Reset while holding a NOT: it is lost, outputs clear
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    rst = 1'b1;
    s_op = 3'd1; s_a = 8'd5; s_b = 8'd9; s_y = 8'd12; s_single = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd0);
    tick(1);
    rst = 1'b0;
    s_valid = 1'b0;
    chk("midrst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("midrst_cnt", {16'b0, fused_cnt}, 32'd0);
    chk("midrst_m_rec", {5'b0, m_op, m_a, m_b, m_y}, 32'd0);
    tick(3);
    chk("midrst_no_out", q.size(), 32'd0);
    send(3'd0, 8'd3, 8'd0, 8'd9, 1'b1, st);
    tick(3);
    chk("postrst_held", q.size(), 32'd0);
    send(3'd1, 8'd5, 8'd9, 8'd12, 1'b0, st);
    tick(3);
    chk("postrst_count", q.size(), 32'd1);
    chk_rec("postrst_rec", 0, rec(3, 5, 3, 12));
    chk("postrst_cnt", {16'b0, fused_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
